// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver/transmitter pair.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  // 19200 baud from a 50 MHz clock
  localparam int unsigned UART_BAUD_DIV_DEFAULT = 2604;

  function automatic logic parity_calc(input logic [8:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter with mid-bit and end-of-bit ticks.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic [$clog2(DIV)-1:0]  cnt,
  output logic                    half_tick,
  output logic                    full_tick
);

  localparam int unsigned CW = $clog2(DIV);

  assign half_tick = (cnt == CW'(DIV / 2 - 1));
  assign full_tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || full_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable serial receiver: 5-9 data bits, optional parity, stop check,
// false-start rejection and sticky overrun reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rx_rdy_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 ovr_err
);

  localparam int unsigned CW  = $clog2(BAUD_DIV);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  rx_state_t state, next_state;

  logic                 rx_meta, rx_s, rx_prev;
  logic                 fall;
  logic                 cnt_clr, half_tick, full_tick;
  logic [CW-1:0]        baud_cnt_unused;
  logic                 shift_en, bit_clr, par_cap, commit;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0]       bit_cnt;
  logic                 par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  uart_baud_cnt #(.DIV(BAUD_DIV)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .cnt       (baud_cnt_unused),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    par_cap    = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          cnt_clr    = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (half_tick) begin
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            cnt_clr    = 1'b1;
            bit_clr    = 1'b1;
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == BCW'(DATA_BITS - 1))
            next_state = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (full_tick) begin
          par_cap    = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      if (bit_clr)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_cap)
        par_bit <= rx_s;
    end
  end

  // The stop sample edge is the commit edge; a coincident ack keeps rx_rdy set
  // but suppresses the overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (commit) begin
      rx_data <= shreg;
      rx_rdy  <= 1'b1;
      frm_err <= ~rx_s;
      par_err <= (PARITY_EN != 0) && (parity_calc(9'(shreg), 1'(PARITY_ODD)) ^ par_bit);
      ovr_err <= ~rx_rdy_clr & (ovr_err | rx_rdy);
    end else if (rx_rdy_clr) begin
      rx_rdy  <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule
